rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
Parametrised integer register file for the core's decode/writeback boundary. It succeeds the fixed 2-read/1-write RF.
- Configurable data width, register count and number of read ports.
- Two write ports with fixed priority.
- Same-cycle write-to-read bypass.
- Hardwired-zero register 0 (optional).
- Handshaked bulk-clear sequencer that zeroes the array one entry per cycle, used on context flush.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (power of two, >=2); localparam AW = $clog2(NREGS)
NRD, 2, number of read ports (>=1)
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  asynchronous, active-high reset
rs_addr_i  input  NRD*AW  read addresses; port k at bits [k*AW +: AW]
rs_data_o  output  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
we0_i  input  1  write enable, port 0 (low priority)
wa0_i  input  AW  write address, port 0
wd0_i  input  XLEN  write data, port 0
we1_i  input  1  write enable, port 1 (high priority)
wa1_i  input  AW  write address, port 1
wd1_i  input  XLEN  write data, port 1
clr_req_i  input  1  bulk-clear request (level, sampled in IDLE)
clr_busy_o  output  1  high while clear sequence runs
clr_done_o  output  1  one-cycle pulse when clear completes

Behaviour:
- Reset (async, reset_i=1): all NREGS entries <= 0; FSM <= IDLE; clear index <= 0; clr_busy_o=0, clr_done_o=0. Reset asserted mid-clear aborts the sequence; the array is still fully zeroed by reset itself.
- Effective write: port p is effective when wep_i=1, FSM=IDLE and not (ZERO_REG=1 and wap_i=0).
- Write timing: an effective write updates the array at the rising edge. It is visible from the array on the following cycle.
- Write collision: both ports effective on the same address -> port 1 data is stored and port 0 is discarded. Different addresses -> both are stored in the same edge.
- Read (combinational, zero latency), per port k, in priority order:
  1. ZERO_REG=1 and addr=0 -> 0.
  2. FSM=IDLE and port 1 effective with wa1_i=addr -> wd1_i.
  3. FSM=IDLE and port 0 effective with wa0_i=addr -> wd0_i.
  4. Otherwise -> stored array value.
- Read ports are fully independent; any number of them may address the same register.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req_i=1 at an edge -> CLEAR, index <= 0. Any write effective in that same cycle is still committed.
  - CLEAR: each edge writes 0 to array[index] and increments index. When index=NREGS-1, that edge -> DONE. CLEAR lasts exactly NREGS cycles. clr_busy_o=1 throughout.
  - While in CLEAR: write ports are ignored (writes dropped, no bypass); reads return the current array contents (partially cleared); clr_req_i is ignored.
  - DONE: clr_done_o=1 and clr_busy_o=0 for exactly one cycle, then unconditionally -> IDLE. clr_req_i held high re-triggers only from IDLE, so a held request yields back-to-back sequences separated by one DONE cycle and one IDLE cycle.
- Index counter is AW bits wide and wraps naturally; no overflow state.
- No X propagation: every output is defined from reset onward.

Test Plan:
1. Reset, then read all addresses on every port -> every rs_data_o = 0. With ZERO_REG=1: write 0xDEADBEEF to reg 0, read reg 0 the next cycle -> 0.
2. Cycle N: we0 writes reg 5 = 0x1234_5678 while port 0 reads reg 5 -> 0x1234_5678 in cycle N (bypass). Cycle N+1, no write -> still 0x1234_5678 (array).
3. Same cycle: we0 (reg 7, 0xAAAA_AAAA) and we1 (reg 7, 0x5555_5555); read reg 7 -> 0x5555_5555 in that cycle and all later cycles. Separately, writes to regs 3 and 4 in one cycle -> both stored.
4. Fill regs 1..31 with their index value, pulse clr_req_i -> clr_busy_o high for exactly 32 cycles, then clr_done_o high for 1 cycle. Sample reg 31 mid-clear -> still 31. After done, every register reads 0.
5. During CLEAR, assert we1 on reg 2 = 0xFFFF_FFFF -> read shows no bypass. After DONE, reg 2 = 0.
6. Assert reset_i asynchronously (between clock edges) at clear cycle 10 -> clr_busy_o drops immediately and all registers read 0. After deassertion, FSM is IDLE and a new write to reg 9 = 0x42 reads back 0x42.

Source files
------------

// File: rtl/rf_multiport.sv
// Parametrised multi-read, dual-write integer register file with same-cycle
// write-to-read bypass, optional hardwired-zero r0 and a one-entry-per-cycle bulk clear.
module rf_multiport #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  input  logic                we0_i,
  input  logic [AW-1:0]       wa0_i,
  input  logic [XLEN-1:0]     wd0_i,
  input  logic                we1_i,
  input  logic [AW-1:0]       wa1_i,
  input  logic [XLEN-1:0]     wd1_i,
  input  logic                clr_req_i,
  output logic                clr_busy_o,
  output logic                clr_done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];
  logic              eff0, eff1;
  logic [AW-1:0]     ra;

  // Writes to r0 are squashed here so neither the array nor the bypass sees them.
  assign eff0 = we0_i && (state_q == S_IDLE) && !((ZERO_REG != 0) && (wa0_i == '0));
  assign eff1 = we1_i && (state_q == S_IDLE) && !((ZERO_REG != 0) && (wa1_i == '0));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clr_req_i) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        clr_busy_o = 1'b1;
        idx_d      = idx_q + 1'b1;
        if (idx_q == AW'(NREGS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        clr_done_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Port 1 is applied after port 0 so it wins on an address collision.
  always_comb begin
    mem_d = mem_q;
    if (state_q == S_CLEAR) begin
      mem_d[idx_q] = '0;
    end else begin
      if (eff0) mem_d[wa0_i] = wd0_i;
      if (eff1) mem_d[wa1_i] = wd1_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    rs_data_o = '0;
    ra        = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      ra = rs_addr_i[k*AW +: AW];
      if ((ZERO_REG != 0) && (ra == '0))
        rs_data_o[k*XLEN +: XLEN] = '0;
      else if (eff1 && (wa1_i == ra))
        rs_data_o[k*XLEN +: XLEN] = wd1_i;
      else if (eff0 && (wa0_i == ra))
        rs_data_o[k*XLEN +: XLEN] = wd0_i;
      else
        rs_data_o[k*XLEN +: XLEN] = mem_q[ra];
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// Directed self-checking bench for rf_multiport (default parameters, 2 read ports).
module tb_rf_multiport;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned AW = 5;

  logic                clk_i = 1'b0;
  logic                reset_i;
  logic [NRD*AW-1:0]   rs_addr_i;
  logic [NRD*XLEN-1:0] rs_data_o;
  logic                we0_i, we1_i;
  logic [AW-1:0]       wa0_i, wa1_i;
  logic [XLEN-1:0]     wd0_i, wd1_i;
  logic                clr_req_i;
  logic                clr_busy_o, clr_done_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cnt;

  rf_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .rs_addr_i(rs_addr_i), .rs_data_o(rs_data_o),
    .we0_i(we0_i), .wa0_i(wa0_i), .wd0_i(wd0_i),
    .we1_i(we1_i), .wa1_i(wa1_i), .wd1_i(wd1_i),
    .clr_req_i(clr_req_i), .clr_busy_o(clr_busy_o), .clr_done_o(clr_done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rs_addr_i = {a1, a0};
    #1;
  endtask

  function automatic logic [31:0] rd0();
    return rs_data_o[0 +: XLEN];
  endfunction

  function automatic logic [31:0] rd1();
    return rs_data_o[XLEN +: XLEN];
  endfunction

  initial begin
    reset_i = 1'b1; rs_addr_i = '0; clr_req_i = 1'b0;
    we0_i = 1'b0; wa0_i = '0; wd0_i = '0;
    we1_i = 1'b0; wa1_i = '0; wd1_i = '0;
    @(negedge clk_i); @(negedge clk_i);
    reset_i = 1'b0;

    // 1: reset state and hardwired r0
    chk("rst_busy", 32'(clr_busy_o), 32'd0);
    chk("rst_done", 32'(clr_done_o), 32'd0);
    for (int a = 0; a < 32; a++) begin
      rd(AW'(a), AW'(31 - a));
      chk("rst_p0", rd0(), 32'd0);
      chk("rst_p1", rd1(), 32'd0);
    end
    we0_i = 1'b1; wa0_i = 5'd0; wd0_i = 32'hDEADBEEF;
    rd(5'd0, 5'd0);
    chk("r0_nobyp", rd0(), 32'd0);
    step(); we0_i = 1'b0;
    rd(5'd0, 5'd0);
    chk("r0_zero", rd0(), 32'd0);

    // 2: bypass then array
    we0_i = 1'b1; wa0_i = 5'd5; wd0_i = 32'h1234_5678;
    rd(5'd5, 5'd1);
    chk("byp5", rd0(), 32'h1234_5678);
    chk("byp_other", rd1(), 32'd0);
    step(); we0_i = 1'b0;
    rd(5'd5, 5'd5);
    chk("arr5", rd0(), 32'h1234_5678);

    // 3: collision and dual write
    we0_i = 1'b1; wa0_i = 5'd7; wd0_i = 32'hAAAA_AAAA;
    we1_i = 1'b1; wa1_i = 5'd7; wd1_i = 32'h5555_5555;
    rd(5'd7, 5'd7);
    chk("coll_byp0", rd0(), 32'h5555_5555);
    chk("coll_byp1", rd1(), 32'h5555_5555);
    step();
    wa0_i = 5'd3; wd0_i = 32'h33; wa1_i = 5'd4; wd1_i = 32'h44;
    rd(5'd7, 5'd3);
    chk("coll_arr", rd0(), 32'h5555_5555);
    chk("dual_byp3", rd1(), 32'h33);
    step(); we0_i = 1'b0; we1_i = 1'b0;
    rd(5'd3, 5'd4);
    chk("dual3", rd0(), 32'h33);
    chk("dual4", rd1(), 32'h44);

    // 4/5: fill, bulk clear, write attempt during clear
    for (int i = 1; i < 32; i++) begin
      we0_i = 1'b1; wa0_i = AW'(i); wd0_i = 32'(i);
      step();
    end
    we0_i = 1'b0;
    rd(5'd31, 5'd17);
    chk("fill31", rd0(), 32'd31);
    chk("fill17", rd1(), 32'd17);
    clr_req_i = 1'b1;
    step();
    clr_req_i = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100 && clr_busy_o; c++) begin
      cnt++;
      if (cnt == 5) begin
        rd(5'd31, 5'd2);
        chk("mid31", rd0(), 32'd31);
        chk("mid_done", 32'(clr_done_o), 32'd0);
      end
      if (cnt == 10) begin
        we1_i = 1'b1; wa1_i = 5'd2; wd1_i = 32'hFFFF_FFFF;
        rd(5'd12, 5'd2);
        chk("clr_nobyp", rd1(), 32'd0);
        chk("clr_part12", rd0(), 32'd12);
      end
      step();
      we1_i = 1'b0;
    end
    chk("busy_cycles", cnt, 32'd32);
    chk("done_pulse", 32'(clr_done_o), 32'd1);
    step();
    chk("done_low", 32'(clr_done_o), 32'd0);
    chk("busy_low", 32'(clr_busy_o), 32'd0);
    for (int a = 0; a < 32; a += 2) begin
      rd(AW'(a), AW'(a + 1));
      chk("post_clr0", rd0(), 32'd0);
      chk("post_clr1", rd1(), 32'd0);
    end

    // 6: async reset mid-clear
    we0_i = 1'b1; wa0_i = 5'd20; wd0_i = 32'h20;
    we1_i = 1'b1; wa1_i = 5'd25; wd1_i = 32'h25;
    step(); we0_i = 1'b0; we1_i = 1'b0;
    clr_req_i = 1'b1;
    step();
    clr_req_i = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rd(5'd20, 5'd25);
    chk("pre_rst20", rd0(), 32'h20);
    chk("pre_rst_busy", 32'(clr_busy_o), 32'd1);
    #1 reset_i = 1'b1;
    #1;
    chk("arst_busy", 32'(clr_busy_o), 32'd0);
    chk("arst20", rd0(), 32'd0);
    chk("arst25", rd1(), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("rel_busy", 32'(clr_busy_o), 32'd0);
    chk("rel_done", 32'(clr_done_o), 32'd0);
    we0_i = 1'b1; wa0_i = 5'd9; wd0_i = 32'h42;
    step(); we0_i = 1'b0;
    rd(5'd9, 5'd9);
    chk("rel_w9", rd0(), 32'h42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
